atm_session_ctrl: RTL and testbench

Card-and-PIN session controller sitting directly upstream of the ATM transaction core. It authenticates a 4-digit BCD PIN against a per-account table and enforces a retry limit with per-account lockout. It then accepts menu requests and drives the core's Select/AccountNumber_s/AccountNumber_d/Amount inputs for one cycle per transaction, capturing the core's result and Balance into registered status outputs.

---
 rtl/atm_pkg.sv | 24 ++
 rtl/atm_session_ctrl_if.sv | 27 ++
 rtl/atm_pin_rom.sv | 16 +
 rtl/atm_session_ctrl.sv | 164 ++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared types and field widths for the ATM session controller and its core bus.
package atm_pkg;

  localparam int unsigned ACCT_W  = 4;
  localparam int unsigned AMT_W   = 10;
  localparam int unsigned PIN_W   = 16;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned RES_W   = 2;

  typedef enum logic [SEL_W-1:0] {
    SEL_EXIT     = 2'd0,
    SEL_BALANCE  = 2'd1,
    SEL_WITHDRAW = 2'd2,
    SEL_TRANSFER = 2'd3
  } sel_t;

  localparam logic [RES_W-1:0] RES_OK = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PIN, ST_CHECK, ST_MENU, ST_ISSUE, ST_WAIT, ST_EJECT, ST_RETAIN
  } state_t;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Menu request handshake plus the transaction-core command/response bus.
interface atm_session_ctrl_if;
  import atm_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [SEL_W-1:0]   req_select;
  logic [AMT_W-1:0]   req_amount;
  logic [ACCT_W-1:0]  req_dest;
  logic [SEL_W-1:0]   atm_select;
  logic [ACCT_W-1:0]  atm_src;
  logic [ACCT_W-1:0]  atm_dst;
  logic [AMT_W-1:0]   atm_amount;
  logic [RES_W-1:0]   atm_result;
  logic [AMT_W-1:0]   atm_balance;

  modport master (
    output req_valid, req_select, req_amount, req_dest, atm_result, atm_balance,
    input  req_ready, atm_select, atm_src, atm_dst, atm_amount
  );

  modport slave (
    input  req_valid, req_select, req_amount, req_dest, atm_result, atm_balance,
    output req_ready, atm_select, atm_src, atm_dst, atm_amount
  );

endinterface

// File: rtl/atm_pin_rom.sv
// Per-account PIN table: account n maps to four BCD digits of n mod 10.
module atm_pin_rom
  import atm_pkg::*;
(
  input  logic [ACCT_W-1:0] acct,
  output logic [PIN_W-1:0]  pin_c
);

  logic [DIGIT_W-1:0] digit;

  always_comb begin
    digit = (acct >= ACCT_W'(10)) ? DIGIT_W'(acct - ACCT_W'(10)) : DIGIT_W'(acct);
    pin_c = {4{digit}};
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// Card/PIN session controller: authenticates, enforces lockout and issues
// one-cycle commands to the ATM transaction core.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               card_valid,
  input  logic [ACCT_W-1:0]  card_acct,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_enter,
  input  logic               key_cancel,
  atm_session_ctrl_if.slave  bus,
  output logic               txn_done,
  output logic               txn_ok,
  output logic [AMT_W-1:0]   balance_out,
  output logic               pin_error,
  output logic               card_eject,
  output logic               card_retained,
  output logic               session_active
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned NACCT  = 2 ** ACCT_W;

  state_t             state, state_n;
  logic [ACCT_W-1:0]  acct;
  logic [PIN_W-1:0]   pin_buf;
  logic [2:0]         dig_cnt;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [NACCT-1:0]   locked;
  logic [SEL_W-1:0]   sel_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [PIN_W-1:0]   pin_ref;
  logic               any_event, tmo_hit, pin_match, last_try, self_xfer;

  atm_pin_rom u_pin_rom (.acct(acct), .pin_c(pin_ref));

  assign any_event = key_valid | key_enter | key_cancel | bus.req_valid;
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign pin_match = (dig_cnt == 3'd4) && (pin_buf == pin_ref);
  assign last_try  = (fail_cnt == FAIL_W'(MAX_TRIES - 1));
  assign self_xfer = (bus.req_select == SEL_TRANSFER) && (bus.req_dest == acct);

  // Next state; an accepted event always beats the idle timeout.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (card_valid) state_n = locked[card_acct] ? ST_RETAIN : ST_PIN;
      ST_PIN: begin
        if (!card_valid || key_cancel)      state_n = ST_EJECT;
        else if (key_enter)                 state_n = ST_CHECK;
        else if (!any_event && tmo_hit)     state_n = ST_EJECT;
      end
      ST_CHECK:  state_n = pin_match ? ST_MENU : (last_try ? ST_RETAIN : ST_PIN);
      ST_MENU: begin
        if (!card_valid)                    state_n = ST_EJECT;
        else if (bus.req_valid) begin
          if (bus.req_select == SEL_EXIT)   state_n = ST_EJECT;
          else if (!self_xfer)              state_n = ST_ISSUE;
        end
        else if (!any_event && tmo_hit)     state_n = ST_EJECT;
      end
      ST_ISSUE:  state_n = ST_WAIT;
      ST_WAIT:   state_n = ST_MENU;
      ST_EJECT,
      ST_RETAIN: if (!card_valid) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Session datapath and registered outputs; the core bus idles at a balance query.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      acct           <= '0;
      pin_buf        <= '0;
      dig_cnt        <= '0;
      fail_cnt       <= '0;
      locked         <= '0;
      sel_q          <= SEL_BALANCE;
      tmo_cnt        <= '0;
      bus.req_ready  <= 1'b0;
      bus.atm_select <= SEL_BALANCE;
      bus.atm_src    <= '0;
      bus.atm_dst    <= '0;
      bus.atm_amount <= '0;
      txn_done       <= 1'b0;
      txn_ok         <= 1'b0;
      balance_out    <= '0;
      pin_error      <= 1'b0;
      card_eject     <= 1'b0;
      card_retained  <= 1'b0;
      session_active <= 1'b0;
    end else begin
      txn_done       <= 1'b0;
      txn_ok         <= 1'b0;
      pin_error      <= 1'b0;
      tmo_cnt        <= '0;
      bus.atm_select <= SEL_BALANCE;
      bus.atm_src    <= acct;
      bus.atm_dst    <= acct;
      bus.atm_amount <= '0;
      case (state)
        ST_IDLE: if (card_valid) begin
          acct        <= card_acct;
          bus.atm_src <= card_acct;
          bus.atm_dst <= card_acct;
          pin_buf     <= '0;
          dig_cnt     <= '0;
          fail_cnt    <= '0;
        end
        ST_PIN: begin
          if (!any_event) tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (key_valid && !key_enter && !key_cancel &&
              key_digit <= DIGIT_W'(9) && dig_cnt < 3'd4) begin
            pin_buf <= {pin_buf[PIN_W-DIGIT_W-1:0], key_digit};
            dig_cnt <= dig_cnt + 3'd1;
          end
        end
        ST_CHECK: begin
          if (pin_match) fail_cnt <= '0;
          else if (last_try) locked[acct] <= 1'b1;
          else begin
            fail_cnt  <= fail_cnt + FAIL_W'(1);
            pin_error <= 1'b1;
            pin_buf   <= '0;
            dig_cnt   <= '0;
          end
        end
        ST_MENU: begin
          if (!any_event) tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (card_valid && bus.req_valid) begin
            if (self_xfer) txn_done <= 1'b1;
            else if (bus.req_select != SEL_EXIT) begin
              sel_q          <= bus.req_select;
              bus.atm_select <= bus.req_select;
              bus.atm_dst    <= (bus.req_select == SEL_TRANSFER) ? bus.req_dest : acct;
              bus.atm_amount <= (bus.req_select == SEL_WITHDRAW ||
                                 bus.req_select == SEL_TRANSFER) ? bus.req_amount : '0;
            end
          end
        end
        ST_WAIT: begin
          txn_done    <= 1'b1;
          txn_ok      <= (sel_q == SEL_BALANCE) || (bus.atm_result == RES_OK);
          balance_out <= bus.atm_balance;
        end
        default: ;
      endcase
      state          <= state_n;
      bus.req_ready  <= (state_n == ST_MENU);
      session_active <= (state_n == ST_MENU) || (state_n == ST_ISSUE) || (state_n == ST_WAIT);
      card_eject     <= (state_n == ST_EJECT);
      card_retained  <= (state_n == ST_RETAIN);
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: stimulus queues expected events, a monitor checks them.
module tb_atm_session_ctrl;
  import atm_pkg::*;

  localparam int unsigned T_OUT = 1000;
  localparam int unsigned TRIES = 3;

  typedef enum int {EV_TXN, EV_PINERR, EV_EJECT, EV_RETAIN} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       ok;
    int       bal;
  } ev_t;
  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] src;
    logic [3:0] dst;
    logic [9:0] amt;
  } bus_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       card_valid = 1'b0;
  logic [3:0] card_acct = '0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = '0;
  logic       key_enter = 1'b0;
  logic       key_cancel = 1'b0;
  logic       txn_done, txn_ok, pin_error, card_eject, card_retained, session_active;
  logic [9:0] balance_out;

  atm_session_ctrl_if bus ();

  atm_session_ctrl #(.MAX_TRIES(TRIES), .TIMEOUT_CYCLES(T_OUT)) dut (
    .clk(clk), .rst(rst), .card_valid(card_valid), .card_acct(card_acct),
    .key_valid(key_valid), .key_digit(key_digit), .key_enter(key_enter),
    .key_cancel(key_cancel), .bus(bus), .txn_done(txn_done), .txn_ok(txn_ok),
    .balance_out(balance_out), .pin_error(pin_error), .card_eject(card_eject),
    .card_retained(card_retained), .session_active(session_active)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   last_bal = 0;
  ev_t  exp_q[$];
  bus_t bus_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  task automatic push_ev(input ev_kind_t k, input int ok, input int bal);
    ev_t e;
    e.kind = k; e.ok = ok; e.bal = bal;
    exp_q.push_back(e);
  endtask

  task automatic take(input string name, input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) miss(name);
    else begin
      e = exp_q.pop_front();
      chk(name, int'(e.kind), int'(k));
    end
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard.
  initial begin
    logic prev_ej, prev_rt, prev_mut, mut;
    ev_t  e;
    bus_t b, act;
    prev_ej = 1'b0; prev_rt = 1'b0; prev_mut = 1'b0;
    forever begin
      @(negedge clk);
      if (txn_done === 1'b1) begin
        if (exp_q.size() == 0) miss("txn_done");
        else begin
          e = exp_q.pop_front();
          chk("txn_kind", int'(e.kind), int'(EV_TXN));
          chk("txn_ok", int'(txn_ok), e.ok);
          chk("balance_out", int'(balance_out), e.bal);
        end
      end
      if (pin_error === 1'b1) take("pin_error", EV_PINERR);
      if (card_eject === 1'b1 && !prev_ej) take("card_eject", EV_EJECT);
      if (card_retained === 1'b1 && !prev_rt) take("card_retained", EV_RETAIN);
      mut = (bus.atm_select !== 2'd1);
      if (mut) begin
        chk("bus_one_cycle", int'(prev_mut), 0);
        act = {bus.atm_select, bus.atm_src, bus.atm_dst, bus.atm_amount};
        if (bus_q.size() == 0) miss("bus_issue");
        else begin
          b = bus_q.pop_front();
          chk("bus_issue", int'(act), int'(b));
        end
      end
      prev_mut = mut;
      prev_ej  = (card_eject === 1'b1);
      prev_rt  = (card_retained === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic insert(input int a);
    card_acct = 4'(a); card_valid = 1'b1; cyc();
  endtask

  task automatic remove();
    card_valid = 1'b0; cyc(2);
  endtask

  task automatic key(input int d);
    key_valid = 1'b1; key_digit = 4'(d); cyc(); key_valid = 1'b0;
  endtask

  task automatic enter();
    key_enter = 1'b1; cyc(); key_enter = 1'b0; cyc();
  endtask

  task automatic login(input int a, input int d);
    insert(a);
    repeat (4) key(d);
    enter();
  endtask

  task automatic request(input int sel, input int amt, input int dest,
                         input int res, input int bal, input int acct);
    bus_t b;
    chk("req_ready", int'(bus.req_ready), 1);
    bus.req_select = 2'(sel); bus.req_amount = 10'(amt); bus.req_dest = 4'(dest);
    bus.atm_result = 2'(res); bus.atm_balance = 10'(bal);
    if (sel == 0) push_ev(EV_EJECT, 0, 0);
    else if (sel == 3 && dest == acct) push_ev(EV_TXN, 0, last_bal);
    else begin
      if (sel != 1) begin
        b.sel = 2'(sel); b.src = 4'(acct);
        b.dst = (sel == 3) ? 4'(dest) : 4'(acct);
        b.amt = 10'(amt);
        bus_q.push_back(b);
      end
      push_ev(EV_TXN, (sel == 1 || res == 3) ? 1 : 0, bal);
      last_bal = bal;
    end
    bus.req_valid = 1'b1; cyc(); bus.req_valid = 1'b0; cyc(2);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_atm_select"}, int'(bus.atm_select), 1);
    chk({tag, "_atm_src"}, int'(bus.atm_src), 0);
    chk({tag, "_atm_amount"}, int'(bus.atm_amount), 0);
    chk({tag, "_req_ready"}, int'(bus.req_ready), 0);
    chk({tag, "_txn_done"}, int'(txn_done), 0);
    chk({tag, "_session_active"}, int'(session_active), 0);
    chk({tag, "_balance_out"}, int'(balance_out), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2); rst = 1'b0;
    last_bal = 0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_select = '0; bus.req_amount = '0; bus.req_dest = '0;
    bus.atm_result = '0; bus.atm_balance = '0;
    do_reset();
    check_reset("rst0");
    chk("rst0_card_eject", int'(card_eject), 0);
    chk("rst0_pin_error", int'(pin_error), 0);

    // Balance query on account 4
    login(4, 4);
    chk("acct4_session_active", int'(session_active), 1);
    request(1, 0, 0, 0, 500, 4);
    request(0, 0, 0, 0, 0, 4);
    remove();

    // Withdraw success and failure on account 3
    login(3, 3);
    request(2, 70, 0, 3, 430, 3);
    request(2, 70, 0, 0, 430, 3);
    request(0, 0, 0, 0, 0, 3);
    remove();

    // Transfer to another account, then to itself, then pull the card
    login(6, 6);
    request(3, 40, 10, 3, 200, 6);
    request(3, 5, 6, 3, 999, 6);
    push_ev(EV_EJECT, 0, 0);
    card_valid = 1'b0; cyc();
    chk("pull_card_eject", int'(card_eject), 1);
    cyc();
    chk("pull_card_idle", int'(card_eject), 0);

    // Three wrong PINs lock account 8
    insert(8);
    for (int t = 0; t < 3; t++) begin
      if (t < 2) push_ev(EV_PINERR, 0, 0);
      else push_ev(EV_RETAIN, 0, 0);
      key(1); key(2); key(3); key(4);
      enter();
    end
    chk("lock_retained", int'(card_retained), 1);
    chk("lock_session_active", int'(session_active), 0);
    remove();
    push_ev(EV_RETAIN, 0, 0);
    insert(8);
    chk("relock_retained", int'(card_retained), 1);
    remove();
    do_reset();
    login(8, 8);
    chk("unlock_session_active", int'(session_active), 1);
    request(0, 0, 0, 0, 0, 8);
    remove();

    // Short PIN, ignored digits, cancel beating enter
    insert(4);
    push_ev(EV_PINERR, 0, 0);
    key(4); key(4); key(4);
    enter();
    chk("short_pin_session", int'(session_active), 0);
    key(4); key(10); key(4); key(4); key(4); key(9);
    enter();
    chk("extra_digit_match", int'(session_active), 1);
    request(0, 0, 0, 0, 0, 4);
    remove();
    insert(5);
    key(5);
    push_ev(EV_EJECT, 0, 0);
    key_cancel = 1'b1; key_enter = 1'b1; cyc();
    key_cancel = 1'b0; key_enter = 1'b0;
    chk("cancel_enter_eject", int'(card_eject), 1);
    remove();

    // Timeout boundary: request on final cycle accepted, then full idle ejects
    login(2, 2);
    cyc(T_OUT - 1);
    chk("tmo_final_no_eject", int'(card_eject), 0);
    request(1, 0, 0, 0, 321, 2);
    chk("tmo_after_req_active", int'(session_active), 1);
    push_ev(EV_EJECT, 0, 0);
    cyc(T_OUT - 1);
    chk("tmo_edge_no_eject", int'(card_eject), 0);
    cyc();
    chk("tmo_eject", int'(card_eject), 1);
    remove();

    // Reset during WAIT
    login(7, 7);
    begin
      bus_t b;
      b.sel = 2'd2; b.src = 4'd7; b.dst = 4'd7; b.amt = 10'd10;
      bus_q.push_back(b);
    end
    bus.req_select = 2'd2; bus.req_amount = 10'd10; bus.req_dest = 4'd7;
    bus.atm_result = 2'd3; bus.atm_balance = 10'd99;
    bus.req_valid = 1'b1; cyc(); bus.req_valid = 1'b0; cyc();
    rst = 1'b1; cyc();
    check_reset("rst_wait");
    rst = 1'b0;
    remove();

    chk("queue_drain", exp_q.size() + bus_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
